// File: rtl/siso_ctrl_pkg.sv
// Shared definitions for the SISO frame controllers (transmit side now, receive side later).
// Frame state names, start-bit level and the counter sizing helper live here.
package siso_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_GAP
    } siso_state_e;

    localparam logic SISO_START_BIT = 1'b1;

    // One counter serves both the data bits and the idle gap, so it must hold the larger limit.
    function automatic int siso_cnt_width(input int width, input int gap);
        int w;
        w = $clog2(width + 1);
        if ($clog2(gap + 1) > w) begin
            w = $clog2(gap + 1);
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/siso_tx_shreg.sv
// WIDTH-bit holding/shift register for the transmit controller.
// Loads a parallel word and presents it MSB-first on q_msb, one bit per shift.
module siso_tx_shreg
    import siso_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_msb
);

    logic [WIDTH-1:0] hold;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
        end else if (load) begin
            hold <= d;
        end else if (shift) begin
            hold <= {hold[WIDTH-2:0], 1'b0};
        end
    end

    assign q_msb = hold[WIDTH-1];

endmodule

// File: rtl/siso_tx_ctrl.sv
// Frame sequencer feeding the SISO shift chain: start bit, WIDTH data bits MSB-first,
// optional even parity bit (build with SISO_TX_PARITY_EN defined), then GAP idle cycles.
module siso_tx_ctrl
    import siso_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             s_out,
    output logic             shift_en,
    output logic             frame_active,
    output logic             frame_done
);

    localparam int               CNT_W     = siso_cnt_width(WIDTH, GAP);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    siso_state_e      state;
    siso_state_e      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic transfer;
    logic frame_end;
    logic load;
    logic shift;
    logic q_msb;
    logic s_out_next;
    logic shift_en_next;
    logic frame_done_next;

`ifdef SISO_TX_PARITY_EN
    logic par;
    logic par_next;
`endif

    siso_tx_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .d     (din),
        .q_msb (q_msb)
    );

    assign transfer = din_valid & din_ready;

    // Next state, counter and the output values of the state being entered; outputs are
    // registered from these so each one lines up with the state it describes.
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        frame_end       = 1'b0;
        load            = 1'b0;
        shift           = 1'b0;
        s_out_next      = 1'b0;
        shift_en_next   = 1'b0;
        frame_done_next = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (transfer) begin
                    state_next = S_START;
                    load       = 1'b1;
                end
            end
            S_START: begin
                state_next = S_DATA;
                cnt_next   = '0;
            end
            S_DATA: begin
                if (cnt == DATA_LAST) begin
`ifdef SISO_TX_PARITY_EN
                    state_next = S_PARITY;
`else
                    frame_end  = 1'b1;
`endif
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
`ifdef SISO_TX_PARITY_EN
            S_PARITY: begin
                frame_end = 1'b1;
            end
`endif
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Last frame bit has just been sent: report it in the cycle that follows.
        if (frame_end) begin
            frame_done_next = 1'b1;
            cnt_next        = '0;
            state_next      = (GAP == 0) ? S_IDLE : S_GAP;
        end

        case (state_next)
            S_START: begin
                s_out_next    = SISO_START_BIT;
                shift_en_next = 1'b1;
            end
            S_DATA: begin
                s_out_next    = q_msb;
                shift_en_next = 1'b1;
                shift         = 1'b1;
            end
`ifdef SISO_TX_PARITY_EN
            S_PARITY: begin
                s_out_next    = par;
                shift_en_next = 1'b1;
            end
`endif
            default: begin
                s_out_next    = 1'b0;
                shift_en_next = 1'b0;
            end
        endcase

`ifdef SISO_TX_PARITY_EN
        // Parity accumulates each data bit as it leaves the shift register.
        par_next = par;
        if (load) begin
            par_next = 1'b0;
        end else if (shift) begin
            par_next = par ^ q_msb;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            din_ready    <= 1'b1;
            s_out        <= 1'b0;
            shift_en     <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
`ifdef SISO_TX_PARITY_EN
            par          <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            din_ready    <= (state_next == S_IDLE);
            s_out        <= s_out_next;
            shift_en     <= shift_en_next;
            frame_active <= (state_next != S_IDLE);
            frame_done   <= frame_done_next;
`ifdef SISO_TX_PARITY_EN
            par          <= par_next;
`endif
        end
    end

endmodule
